// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: runtime-configurable UART receiver
// feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLK_HZ      = 100000000,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  BAUD,
  input  logic                        EIGHT,
  input  logic                        PEN,
  input  logic                        OHEL,
  input  logic                        RX_in,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        rd_perr,
  output logic                        rd_ferr,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        ovf,
  output logic                        rx_busy
);

  localparam int CW = $clog2(CLK_HZ / 300 + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  function automatic logic [CW-1:0] bit_time(
    input logic [3:0] b
  );
    case (b)
      4'd0:    bit_time = CW'(CLK_HZ / 300);
      4'd1:    bit_time = CW'(CLK_HZ / 1200);
      4'd2:    bit_time = CW'(CLK_HZ / 2400);
      4'd3:    bit_time = CW'(CLK_HZ / 4800);
      4'd4:    bit_time = CW'(CLK_HZ / 9600);
      4'd5:    bit_time = CW'(CLK_HZ / 19200);
      4'd6:    bit_time = CW'(CLK_HZ / 38400);
      4'd7:    bit_time = CW'(CLK_HZ / 57600);
      4'd8:    bit_time = CW'(CLK_HZ / 115200);
      4'd9:    bit_time = CW'(CLK_HZ / 230400);
      4'd10:   bit_time = CW'(CLK_HZ / 460800);
      default: bit_time = CW'(CLK_HZ / 921600);
    endcase
  endfunction

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_prev, fall;
  logic [CW-1:0]          cnt, bt, lim;
  logic                   sample;
  logic [3:0]             baud_q;
  logic                   eight_q, pen_q, ohel_q;
  logic [2:0]             bidx, last_bit;
  logic [7:0]             sh;
  logic                   perr_q;
  logic                   push;
  logic [9:0]             wdata;

  assign rx_s     = sync[SYNC_STAGES-1];
  assign fall     = rx_prev & ~rx_s;
  assign bt       = bit_time(baud_q);
  assign lim      = (state == START) ? (bt >> 1) : bt;
  assign sample   = (state != IDLE) &&
                    (cnt == lim - CW'(1));
  assign last_bit = eight_q ? 3'd7 : 3'd6;
  assign rx_busy  = (state != IDLE);
  assign push     = (state == STOP) && sample;
  assign wdata    = {perr_q, ~rx_s, sh};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (fall) state_n = START;
      START:  if (sample) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (sample && bidx == last_bit)
          state_n = pen_q ? PARITY : STOP;
      PARITY: if (sample) state_n = STOP;
      STOP:   if (sample) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '1;
      rx_prev <= 1'b1;
      cnt     <= '0;
      baud_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      bidx    <= '0;
      sh      <= '0;
      perr_q  <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], RX_in};
      rx_prev <= rx_s;
      if (state == IDLE) begin
        cnt <= '0;
        // frame format is frozen at the start edge
        if (fall) begin
          baud_q  <= BAUD;
          eight_q <= EIGHT;
          pen_q   <= PEN;
          ohel_q  <= OHEL;
          bidx    <= '0;
          sh      <= '0;
          perr_q  <= 1'b0;
        end
      end else if (sample) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (state == DATA && sample) begin
        sh[bidx] <= rx_s;
        bidx     <= bidx + 3'd1;
      end
      if (state == PARITY && sample)
        perr_q <= ((^sh) ^ rx_s) != ohel_q;
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;
  logic [AW-1:0] wp, rp;
  logic [NW-1:0] count_n;
  logic          pop, wr;

  assign pop = rd_en & ~empty;
  assign wr  = push & (~full | pop);
  assign {rd_perr, rd_ferr, rd_data} = head;

  always_comb begin
    count_n = count;
    if (wr && !pop)      count_n = count + NW'(1);
    else if (pop && !wr) count_n = count - NW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      head  <= '0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == NW'(FIFO_DEPTH));
      if (pop)            ovf <= 1'b0;
      else if (push && full) ovf <= 1'b1;
      // head register keeps its value once drained
      if (pop && count > NW'(1))
        head <= mem[rp + AW'(1)];
      else if (wr && (count == '0 || pop))
        head <= wdata;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo
// at a reduced clock so frames are 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int CLK_HZ   = 1843200;
  localparam int BT       = 16;
  localparam int HT       = 8;
  localparam int PUSH_NEG = 2 + HT + 9 * BT;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] BAUD;
  logic       EIGHT, PEN, OHEL;
  logic       RX_in, rd_en;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr;
  logic       empty, full, ovf, rx_busy;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ),
    .FIFO_DEPTH(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .BAUD(BAUD),
    .EIGHT(EIGHT),
    .PEN(PEN),
    .OHEL(OHEL),
    .RX_in(RX_in),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_perr(rd_perr),
    .rd_ferr(rd_ferr),
    .empty(empty),
    .full(full),
    .count(count),
    .ovf(ovf),
    .rx_busy(rx_busy)
  );

  task automatic send(
    input logic [7:0] d,
    input logic pbit,
    input logic stop
  );
    logic [7:0] dm;
    logic       pe;
    int         nb;
    dm = EIGHT ? d : {1'b0, d[6:0]};
    pe = PEN ? (((^dm) ^ pbit) != OHEL) : 1'b0;
    nb = EIGHT ? 8 : 7;
    sb.push_back({pe, ~stop, dm});
    RX_in = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      RX_in = d[i];
      repeat (BT) @(negedge clk);
    end
    if (PEN) begin
      RX_in = pbit;
      repeat (BT) @(negedge clk);
    end
    RX_in = stop;
    repeat (BT) @(negedge clk);
  endtask

  task automatic read_entry(
    output logic [9:0] got,
    output bit ok
  );
    ok = 1'b0;
    for (int i = 0; i < 4 * BT; i++) begin
      if (!empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    got = {rd_perr, rd_ferr, rd_data};
    if (ok) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({empty, full, ovf, rx_busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 1000",
               {empty, full, ovf, rx_busy});
    end
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_checks++;
    if ({rd_perr, rd_ferr, rd_data} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_head: got %h expected 000",
               {rd_perr, rd_ferr, rd_data});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [9:0] got, exp;
    bit ok;
    send(8'hA5, 1'b0, 1'b1);
    n_checks++;
    if (empty !== 1'b0 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_fill: got empty=%b count=%0d expected 0/1",
               empty, count);
    end
    read_entry(got, ok);
    exp = sb.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL basic_data: got %h expected %h", got, exp);
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_parity();
    logic [9:0] got, exp;
    bit ok;
    EIGHT = 1'b0;
    PEN   = 1'b1;
    OHEL  = 1'b1;
    send(8'h41, 1'b1, 1'b1);
    send(8'h41, 1'b0, 1'b1);
    OHEL = 1'b0;
    send(8'h41, 1'b0, 1'b1);
    send(8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read_entry(got, ok);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL parity_%0d: got %h expected %h",
                 i, got, exp);
      end
    end
    EIGHT = 1'b1;
    PEN   = 1'b0;
    OHEL  = 1'b0;
  endtask

  task automatic test_framing();
    logic [9:0] got, exp;
    bit ok;
    send(8'h55, 1'b0, 1'b0);
    repeat (3 * BT) @(negedge clk);
    n_checks++;
    if (count !== 4'd1 || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_hold: got count=%0d busy=%b expected 1/0",
               count, rx_busy);
    end
    RX_in = 1'b1;
    repeat (2 * BT) @(negedge clk);
    send(8'h12, 1'b0, 1'b1);
    n_checks++;
    if (count !== 4'd2) begin
      n_fail++;
      $display("FAIL ferr_next: got count=%0d expected 2", count);
    end
    for (int i = 0; i < 2; i++) begin
      read_entry(got, ok);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL ferr_data_%0d: got %h expected %h",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    bit seen;
    seen  = 1'b0;
    RX_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    RX_in = 1'b1;
    for (int i = 0; i < 2 * BT; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    n_checks++;
    if (!seen || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: got seen=%0d busy=%b expected 1/0",
               seen, rx_busy);
    end
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_write: got count=%0d empty=%b expected 0/1",
               count, empty);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] got, exp;
    bit ok;
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b1);
    sb.delete(8);
    n_checks++;
    if ({full, ovf} !== 2'b11 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_state: got full=%b ovf=%b count=%0d expected 1/1/8",
               full, ovf, count);
    end
    for (int i = 0; i < 8; i++) begin
      read_entry(got, ok);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL ovf_data_%0d: got %h expected %h",
                 i, got, exp);
      end
      if (i == 0) begin
        n_checks++;
        if (ovf !== 1'b0 || count !== 4'd7) begin
          n_fail++;
          $display("FAIL ovf_clear: got ovf=%b count=%0d expected 0/7",
                   ovf, count);
        end
      end
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL ovf_drain: got empty=%b count=%0d expected 1/0",
               empty, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, exp;
    bit ok;
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b0, 1'b1);
    n_checks++;
    if (full !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_fill: got full=%b ovf=%b expected 1/0",
               full, ovf);
    end
    fork
      send(8'h88, 1'b0, 1'b1);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    sb.delete(0);
    n_checks++;
    if (count !== 4'd8 || {full, ovf} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_pushpop: got count=%0d full=%b ovf=%b expected 8/1/0",
               count, full, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      read_entry(got, ok);
      exp = sb.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL b2b_data_%0d: got %h expected %h",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got, exp;
    logic [7:0] d;
    bit ok;
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    n_checks++;
    if (count !== 4'd3) begin
      n_fail++;
      $display("FAIL rst_pre: got count=%0d expected 3", count);
    end
    d = 8'h77;
    RX_in = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RX_in = d[i];
      repeat (BT) @(negedge clk);
    end
    RX_in = d[3];
    repeat (HT) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({empty, full, rx_busy} !== 3'b100 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got empty=%b full=%b busy=%b count=%0d expected 1/0/0/0",
               empty, full, rx_busy, count);
    end
    sb.delete();
    RX_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BT) @(negedge clk);
    send(8'h3C, 1'b0, 1'b1);
    read_entry(got, ok);
    exp = sb.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL rst_after: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    RX_in = 1'b1;
    rd_en = 1'b0;
    BAUD  = 4'd8;
    EIGHT = 1'b1;
    PEN   = 1'b0;
    OHEL  = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a buffered, first-word-fall-through receive FIFO. It replaces the fixed single-register receive path inside the UART core. Frame format (7/8 data bits, parity enable, odd/even) and baud rate are selected at runtime. Each received byte is stored with its own parity and framing error flags, so software (TramelBlaze) can drain bursts without losing characters.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; used to derive bit times.
FIFO_DEPTH, 8, receive FIFO entries; power of 2, minimum 2.
SYNC_STAGES, 2, RX synchroniser flops; minimum 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
BAUD  in  4  baud select (see Behaviour)
EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
PEN  in  1  parity enable
OHEL  in  1  parity sense: 1 = odd, 0 = even
RX_in  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop head entry when not empty
rd_data  out  8  head data byte; bit 7 = 0 for 7-bit frames
rd_perr  out  1  head entry parity error
rd_ferr  out  1  head entry framing error
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  entries held
ovf  out  1  sticky overflow flag
rx_busy  out  1  frame in progress

Behaviour:
- Reset (async): state IDLE, FIFO pointers and count 0, empty=1, full=0, ovf=0, rx_busy=0, rd_data/rd_perr/rd_ferr = 0, synchroniser flops = 1.
- Baud table: BAUD 0..B = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; C..F = 921600. Bit time BT = CLK_HZ/rate (integer division), e.g. 868 clocks at 115200 and 100 MHz. Half time HT = BT/2.
- Config latch: BAUD, EIGHT, PEN, OHEL are captured on the start-bit edge. Changes mid-frame have no effect until the next frame.
- FSM, driven by the synchronised RX:
  - IDLE: a falling edge (1 then 0) moves to START, clears the bit counter, and sets rx_busy=1.
  - START: after HT clocks, sample RX. If 0, go to DATA and reload the counter with BT. If 1 (glitch), return to IDLE with rx_busy=0 and write nothing.
  - DATA: sample every BT clocks, LSB first. Shift in 7 or 8 bits, then go to PARITY if PEN=1, otherwise STOP.
  - PARITY: sample one bit. perr = (XOR of data bits XOR parity bit) != OHEL. perr=0 when PEN=0.
  - STOP: sample one bit; ferr = ~bit. Push {perr, ferr, data} to the FIFO the same cycle, return to IDLE, rx_busy=0.
  - A line held low after a framing error is not re-detected as a start until RX returns high (edge-based detection).
- FIFO behaviour:
  - First-word fall-through: rd_data/rd_perr/rd_ferr always present the head entry. They hold their last value when empty.
  - A pop (rd_en=1 and empty=0) advances the head; the new head is visible the next cycle.
  - rd_en while empty is ignored.
  - A push when full and with no pop in the same cycle drops the entry and sets ovf=1.
  - A push and a pop in the same cycle are both honoured, including when full (count unchanged).
  - ovf clears on the next successful pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - count, empty and full are registered and consistent in the same cycle.
- Latency: from the mid-stop-bit sample to empty deasserting is 1 clock.

Test Plan:
- Parameters CLK_HZ=100e6, BAUD=8, EIGHT=1, PEN=0; send 0xA5 with a valid stop bit -> within BT+1 clocks of mid-stop, empty=0, rd_data=0xA5, perr=0, ferr=0, count=1.
- EIGHT=0, PEN=1, OHEL=1 (7-bit, odd); send 0x41 with parity bit 1 -> rd_data=0x41, perr=0. Repeat with parity bit 0 -> perr=1.
- Send 0x55 with stop bit 0 -> entry written with ferr=1. Then hold RX low for 3 BT -> no further entries until RX has gone high and then low again.
- FIFO_DEPTH=8, rd_en=0; send 9 bytes 0x01..0x09 -> full=1, count=8, ovf=1. Pop 8 times -> reads 0x01..0x08 in order, ovf=0 after the first pop, empty=1.
- A 0.3·BT low glitch on RX -> returns to IDLE, nothing written, rx_busy pulses then returns to 0. With the FIFO full, a push and a pop in the same cycle -> count stays 8, ovf stays 0.
- Assert reset mid-DATA with 3 entries queued -> immediately empty=1, count=0, rx_busy=0. After release, the next clean frame 0x3C is received correctly.
